// File: rtl/periph_bus_rr_arbiter.sv
// periph_bus_rr_arbiter
// Round-robin arbiter sharing one cluster peripheral target port among
// N_REQ core-side requesters. Each cycle one request is forwarded to the
// target. The winner's index is queued in an in-order ID FIFO, and every
// target response is routed back to the requester at the FIFO head.
// The block also drives per-requester stall pulses for the performance
// counters and a sticky flag for responses that arrive with no owner.
module periph_bus_rr_arbiter #(
    parameter int N_REQ           = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,

    // Core-side requesters (requester k occupies slice k)
    input  logic [N_REQ-1:0]                     req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]          add_i,
    input  logic [N_REQ-1:0]                     wen_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]          wdata_i,
    input  logic [N_REQ*BE_WIDTH-1:0]            be_i,
    output logic [N_REQ-1:0]                     gnt_o,
    output logic [N_REQ-1:0]                     r_valid_o,
    output logic [DATA_WIDTH-1:0]                r_rdata_o,
    output logic                                 r_opc_o,

    // Shared target port
    output logic                                 tgt_req_o,
    output logic [ADDR_WIDTH-1:0]                tgt_add_o,
    output logic                                 tgt_wen_o,
    output logic [DATA_WIDTH-1:0]                tgt_wdata_o,
    output logic [BE_WIDTH-1:0]                  tgt_be_o,
    input  logic                                 tgt_gnt_i,
    input  logic                                 tgt_r_valid_i,
    input  logic [DATA_WIDTH-1:0]                tgt_r_rdata_i,
    input  logic                                 tgt_r_opc_i,

    // Status
    output logic [N_REQ-1:0]                     stall_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_rsp_o
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]    N_REQ_EXT = (ID_W + 1)'(N_REQ);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  sel;
    logic             any_req;
    logic [ID_W:0]    cand;
    logic [ID_W-1:0]  rr_next;
    logic [ID_W-1:0]  head_id;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             orphan_rsp;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;

    // Round-robin scan: first active request starting at rr_q, wrapping at N_REQ.
    // NOTE: every variable written here gets a default before the loop, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel     = rr_q;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (ID_W + 1)'(i);
            if (cand >= N_REQ_EXT) begin
                cand = cand - N_REQ_EXT;
            end
            if (!any_req && req_i[cand[ID_W-1:0]]) begin
                any_req = 1'b1;
                sel     = cand[ID_W-1:0];
            end
        end
    end

    // Occupancy flags use the registered count, so a pop cannot free a slot
    // for a push in the same cycle.
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign head_id    = fifo_q[rd_ptr_q];

    // Request path to the target, fully combinational.
    assign tgt_req_o   = any_req & ~fifo_full & rst_ni;
    assign tgt_add_o   = add_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign tgt_wen_o   = wen_i[sel];
    assign tgt_wdata_o = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign tgt_be_o    = be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];

    // A handshake pushes the winner; an owned response pops the head.
    assign push       = tgt_req_o & tgt_gnt_i;
    assign pop        = rst_ni & tgt_r_valid_i & ~fifo_empty;
    assign orphan_rsp = tgt_r_valid_i & fifo_empty;

    // Next pointer values, wrapping at the FIFO depth (need not be a power of two).
    assign wr_ptr_next = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    assign rd_ptr_next = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    assign rr_next     = (sel == ID_LAST) ? '0 : sel + ID_W'(1);

    // Grant decode: one-hot on the selected requester when the target accepts.
    always_comb begin
        gnt_o = '0;
        if (push) begin
            gnt_o[sel] = 1'b1;
        end
    end

    // Response routing: one-hot on the requester recorded at the FIFO head.
    always_comb begin
        r_valid_o = '0;
        if (pop) begin
            r_valid_o[head_id] = 1'b1;
        end
    end

    // Response payload is shared; each requester qualifies it with its own valid bit.
    assign r_rdata_o = tgt_r_rdata_i;
    assign r_opc_o   = tgt_r_opc_i;

    // Stall pulse for requesters waiting this cycle.
    assign stall_o       = req_i & ~gnt_o;
    assign outstanding_o = count_q;
    assign err_rsp_o     = err_q;

    // Round-robin pointer: advance past the winner on every handshake.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (push) begin
            rr_q <= rr_next;
        end
    end

    // ID FIFO storage, written on push.
    // NOTE: storage is not reset. The count and pointers are reset, and they
    // ensure a stale entry is never read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

    // ID FIFO pointers and occupancy count.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_next;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_next;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flag: set by a response with no owner, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (orphan_rsp) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_periph_bus_rr_arbiter.sv
// Self-checking bench for periph_bus_rr_arbiter.
// Stimulus is driven one cycle at a time. A small reference model holds the
// round-robin pointer and an expected-ID queue, which is the scoreboard:
// an entry is pushed when a grant is expected and popped when a response is
// expected. Directed constant checks cover the key scenarios.
module tb_periph_bus_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [N-1:0]      req_i;
    logic [N*AW-1:0]   add_i;
    logic [N-1:0]      wen_i;
    logic [N*DW-1:0]   wdata_i;
    logic [N*BW-1:0]   be_i;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      r_valid_o;
    logic [DW-1:0]     r_rdata_o;
    logic              r_opc_o;
    logic              tgt_req_o;
    logic [AW-1:0]     tgt_add_o;
    logic              tgt_wen_o;
    logic [DW-1:0]     tgt_wdata_o;
    logic [BW-1:0]     tgt_be_o;
    logic              tgt_gnt_i;
    logic              tgt_r_valid_i;
    logic [DW-1:0]     tgt_r_rdata_i;
    logic              tgt_r_opc_i;
    logic [N-1:0]      stall_o;
    logic [CW-1:0]     outstanding_o;
    logic              err_rsp_o;

    periph_bus_rr_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .add_i(add_i), .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o),
        .tgt_req_o(tgt_req_o), .tgt_add_o(tgt_add_o), .tgt_wen_o(tgt_wen_o),
        .tgt_wdata_o(tgt_wdata_o), .tgt_be_o(tgt_be_o), .tgt_gnt_i(tgt_gnt_i),
        .tgt_r_valid_i(tgt_r_valid_i), .tgt_r_rdata_i(tgt_r_rdata_i), .tgt_r_opc_i(tgt_r_opc_i),
        .stall_o(stall_o), .outstanding_o(outstanding_o), .err_rsp_o(err_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state
    int   m_rr = 0;
    int   id_q[$];
    logic m_err = 1'b0;

    // Model updates computed at the sample point and applied at the edge
    logic p_rst, p_hs, p_pop, p_errset;
    int   p_sel;

    // Per-requester request fields, chosen so each requester is distinguishable
    function automatic logic [AW-1:0] addr_of(input int k);
        return 32'h4000_0000 + AW'(k * 16);
    endfunction
    function automatic logic [DW-1:0] wdata_of(input int k);
        return 32'hD00D_0000 | DW'(k);
    endfunction
    function automatic logic [BW-1:0] be_of(input int k);
        return BW'(k + 1);
    endfunction
    function automatic logic wen_of(input int k);
        return (k % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [N-1:0] req, input logic tgnt,
                         input logic rv, input logic [DW-1:0] rdata, input logic opc);
        rst_ni        = rst;
        req_i         = req;
        tgt_gnt_i     = tgnt;
        tgt_r_valid_i = rv;
        tgt_r_rdata_i = rdata;
        tgt_r_opc_i   = opc;
    endtask

    // Wait for the sample point, compare all outputs against the model, and
    // record the model update for the next edge.
    task automatic settle(input string tag);
        logic         any;
        logic         full;
        logic         treq;
        int           sel;
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        logic [N-1:0] one;
        @(negedge clk_i);
        one = 1;
        any = 1'b0;
        sel = 0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_rr + i) % N;
            if (!any && req_i[k]) begin
                any = 1'b1;
                sel = k;
            end
        end
        full = (id_q.size() >= MO);
        treq = rst_ni && any && !full;
        eg   = (treq && tgt_gnt_i) ? (one << sel) : '0;
        ev   = (rst_ni && tgt_r_valid_i && id_q.size() > 0) ? (one << id_q[0]) : '0;
        check({tag, "_treq"},  tgt_req_o, treq);
        check({tag, "_gnt"},   gnt_o, eg);
        check({tag, "_rval"},  r_valid_o, ev);
        check({tag, "_stall"}, stall_o, req_i & ~eg);
        check({tag, "_outst"}, outstanding_o, id_q.size());
        check({tag, "_err"},   err_rsp_o, m_err);
        if (treq) begin
            check({tag, "_add"},   tgt_add_o, addr_of(sel));
            check({tag, "_wdata"}, tgt_wdata_o, wdata_of(sel));
            check({tag, "_be"},    tgt_be_o, be_of(sel));
            check({tag, "_wen"},   tgt_wen_o, wen_of(sel));
        end
        if (ev != '0) begin
            check({tag, "_rdata"}, r_rdata_o, tgt_r_rdata_i);
            check({tag, "_opc"},   r_opc_o, tgt_r_opc_i);
        end
        p_rst    = !rst_ni;
        p_hs     = treq && tgt_gnt_i;
        p_sel    = sel;
        p_pop    = (ev != '0);
        p_errset = rst_ni && tgt_r_valid_i && (id_q.size() == 0);
    endtask

    // Apply the recorded model update, cross the edge and step off it.
    task automatic advance();
        if (p_rst) begin
            m_rr  = 0;
            id_q.delete();
            m_err = 1'b0;
        end else begin
            if (p_pop) void'(id_q.pop_front());
            if (p_errset) m_err = 1'b1;
            if (p_hs) begin
                id_q.push_back(p_sel);
                m_rr = (p_sel + 1) % N;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input string tag);
        settle(tag);
        advance();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            add_i[k*AW +: AW]   = addr_of(k);
            wdata_i[k*DW +: DW] = wdata_of(k);
            be_i[k*BW +: BW]    = be_of(k);
            wen_i[k]            = wen_of(k);
        end

        // Reset with all requests present: nothing may reach the target.
        drive(1'b0, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
        step("rst0");
        settle("rst1");
        check("rst_treq", tgt_req_o, 1'b0);
        check("rst_gnt", gnt_o, 4'b0000);
        advance();

        // Target not granting: no grant, every requester stalls, pointer holds.
        drive(1'b1, 4'b1111, 1'b0, 1'b0, '0, 1'b0);
        settle("nognt");
        check("nognt_stall", stall_o, 4'b1111);
        advance();

        // Full throughput round robin, response one cycle after each grant.
        for (int i = 0; i < 8; i++) begin
            logic [N-1:0] one;
            one = 1;
            drive(1'b1, 4'b1111, 1'b1, i > 0, 32'h1111_0000 + DW'(i), 1'b0);
            settle("rr");
            check("rr_order", gnt_o, one << (i % 4));
            if (i > 0) check("rr_rsp", r_valid_o, one << ((i - 1) % 4));
            advance();
        end
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 32'h1111_0008, 1'b0);
        settle("rr_tail");
        check("rr_tail_rsp", r_valid_o, 4'b1000);
        advance();

        // Move the pointer to 2, then check that requester 0 wins over requester 1.
        drive(1'b1, 4'b0001, 1'b1, 1'b0, '0, 1'b0);
        step("setup0");
        drive(1'b1, 4'b0010, 1'b1, 1'b1, 32'h2222_0000, 1'b0);
        step("setup1");
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 32'h2222_0001, 1'b0);
        step("setup2");
        drive(1'b1, 4'b0011, 1'b1, 1'b0, '0, 1'b0);
        settle("wrap");
        check("wrap_gnt", gnt_o, 4'b0001);
        check("wrap_stall", stall_o, 4'b0010);
        advance();
        drive(1'b1, 4'b0010, 1'b1, 1'b0, '0, 1'b0);
        settle("wrap2");
        check("wrap2_gnt", gnt_o, 4'b0010);
        advance();
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 32'h3333_0000, 1'b0);
        step("drain_a");
        step("drain_b");

        // Full FIFO: two grants, then a block; a same-cycle pop does not unblock.
        drive(1'b1, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
        step("fill0");
        step("fill1");
        settle("full");
        check("full_treq", tgt_req_o, 1'b0);
        check("full_outst", outstanding_o, 2);
        advance();
        drive(1'b1, 4'b1111, 1'b1, 1'b1, 32'h4444_0000, 1'b0);
        settle("full_pop");
        check("full_pop_gnt", gnt_o, 4'b0000);
        check("full_pop_rval", r_valid_o, 4'b0100);
        advance();
        drive(1'b1, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
        settle("unblock");
        check("unblock_gnt", gnt_o, 4'b0001);
        advance();
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 32'h4444_0001, 1'b0);
        step("drain_c");
        step("drain_d");

        // Requesters 1 then 3; response data and error flag are passed through.
        drive(1'b1, 4'b1010, 1'b1, 1'b0, '0, 1'b0);
        settle("pt0");
        check("pt0_gnt", gnt_o, 4'b0010);
        advance();
        drive(1'b1, 4'b1000, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0);
        settle("pt1");
        check("pt1_gnt", gnt_o, 4'b1000);
        check("pt1_rval", r_valid_o, 4'b0010);
        check("pt1_rdata", r_rdata_o, 32'hA5A5_0001);
        check("pt1_opc", r_opc_o, 1'b0);
        advance();
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 32'hA5A5_0003, 1'b1);
        settle("pt2");
        check("pt2_rval", r_valid_o, 4'b1000);
        check("pt2_rdata", r_rdata_o, 32'hA5A5_0003);
        check("pt2_opc", r_opc_o, 1'b1);
        advance();

        // Response with empty FIFO: not routed, sticky error, cleared by reset.
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 32'hDEAD_0000, 1'b0);
        settle("orph");
        check("orph_rval", r_valid_o, 4'b0000);
        advance();
        drive(1'b1, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
        step("orph_hold0");
        settle("orph_hold1");
        check("orph_err", err_rsp_o, 1'b1);
        advance();
        drive(1'b0, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
        step("orph_rst");
        drive(1'b1, 4'b0000, 1'b1, 1'b0, '0, 1'b0);
        settle("orph_clr");
        check("orph_clr_err", err_rsp_o, 1'b0);
        advance();

        // Reset with two outstanding: IDs discarded, late response flags error.
        drive(1'b1, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
        step("mid0");
        step("mid1");
        drive(1'b0, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
        settle("mid_rst");
        check("mid_rst_treq", tgt_req_o, 1'b0);
        check("mid_rst_outst", outstanding_o, 2);
        advance();
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 32'hBEEF_0000, 1'b0);
        settle("late");
        check("late_outst", outstanding_o, 0);
        check("late_rval", r_valid_o, 4'b0000);
        advance();
        drive(1'b1, 4'b1111, 1'b1, 1'b0, '0, 1'b0);
        settle("post");
        check("post_err", err_rsp_o, 1'b1);
        check("post_gnt", gnt_o, 4'b0001);
        advance();
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 32'hBEEF_0001, 1'b0);
        step("post_drain");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
